// File: rtl/dcache_blocking.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// dcache_blocking : blocking direct-mapped write-back/write-allocate D-cache
// Revision 1.0
// ---------------------------------------------------------------------------
module dcache_blocking #(
    parameter int LINES = 16,
    parameter int TAG_W = 28 - $clog2(LINES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req_valid,
    output logic          cpu_req_ready,
    input  logic [29:0]   cpu_req_addr,
    input  logic [31:0]   cpu_req_data,
    input  logic [3:0]    cpu_req_write,
    output logic          cpu_resp_valid,
    output logic [31:0]   cpu_resp_data,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [27:0]   mem_req_addr,
    output logic          mem_req_rw,
    output logic          mem_req_data_valid,
    input  logic          mem_req_data_ready,
    output logic [127:0]  mem_req_data_bits,
    output logic [15:0]   mem_req_data_mask,
    input  logic          mem_resp_valid,
    input  logic [127:0]  mem_resp_data
);

    localparam int IDX = $clog2(LINES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COMPARE   = 3'd1,
        S_WB_REQ    = 3'd2,
        S_WB_DATA   = 3'd3,
        S_FILL_REQ  = 3'd4,
        S_FILL_WAIT = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [29:0]        req_addr_q;
    logic [31:0]        req_data_q;
    logic [3:0]         req_write_q;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [127:0]       line_q [LINES];
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_data_q, resp_data_d;

    logic [IDX-1:0]     w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [1:0]         w_off;
    logic [127:0]       w_line;
    logic [31:0]        w_word;
    logic [31:0]        w_merged_word;
    logic [127:0]       w_merged_line;
    logic               w_hit;
    logic               w_line_we;
    logic [127:0]       w_line_wdata;
    logic               w_tag_we;

    assign w_idx  = req_addr_q[IDX+1:2];
    assign w_tag  = req_addr_q[29:IDX+2];
    assign w_off  = req_addr_q[1:0];
    assign w_line = line_q[w_idx];
    assign w_word = w_line[{w_off, 5'd0} +: 32];
    assign w_hit  = valid_q[w_idx] && (tag_q[w_idx] == w_tag);

    always_comb begin
        w_merged_word = w_word;
        for (int b = 0; b < 4; b++) begin
            if (req_write_q[b]) begin
                w_merged_word[8*b +: 8] = req_data_q[8*b +: 8];
            end
        end
        w_merged_line = w_line;
        w_merged_line[{w_off, 5'd0} +: 32] = w_merged_word;
    end

    assign cpu_resp_valid    = resp_valid_q;
    assign cpu_resp_data     = resp_data_q;
    assign mem_req_data_bits = w_line;
    assign mem_req_data_mask = 16'hFFFF;

    always_comb begin
        state_d            = state_q;
        valid_d            = valid_q;
        dirty_d            = dirty_q;
        resp_valid_d       = 1'b0;
        resp_data_d        = resp_data_q;
        w_line_we          = 1'b0;
        w_line_wdata       = w_merged_line;
        w_tag_we           = 1'b0;
        cpu_req_ready      = 1'b0;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = {w_tag, w_idx};
        mem_req_data_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) begin
                    state_d = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (w_hit) begin
                    if (req_write_q == 4'b0000) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = w_word;
                    end else begin
                        w_line_we      = 1'b1;
                        dirty_d[w_idx] = 1'b1;
                    end
                    state_d = S_IDLE;
                end else if (valid_q[w_idx] && dirty_q[w_idx]) begin
                    state_d = S_WB_REQ;
                end else begin
                    state_d = S_FILL_REQ;
                end
            end
            S_WB_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {tag_q[w_idx], w_idx};
                if (mem_req_ready) begin
                    state_d = S_WB_DATA;
                end
            end
            S_WB_DATA: begin
                mem_req_data_valid = 1'b1;
                if (mem_req_data_ready) begin
                    dirty_d[w_idx] = 1'b0;
                    state_d        = S_FILL_REQ;
                end
            end
            S_FILL_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = S_FILL_WAIT;
                end
            end
            S_FILL_WAIT: begin
                if (mem_resp_valid) begin
                    w_line_we      = 1'b1;
                    w_line_wdata   = mem_resp_data;
                    w_tag_we       = 1'b1;
                    valid_d[w_idx] = 1'b1;
                    dirty_d[w_idx] = 1'b0;
                    // Re-enter COMPARE so the access finishes through the hit path.
                    state_d        = S_COMPARE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            dirty_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Request, tag and data storage carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (cpu_req_valid && cpu_req_ready) begin
            req_addr_q  <= cpu_req_addr;
            req_data_q  <= cpu_req_data;
            req_write_q <= cpu_req_write;
        end
        if (w_line_we) begin
            line_q[w_idx] <= w_line_wdata;
        end
        if (w_tag_we) begin
            tag_q[w_idx] <= w_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_blocking.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dcache_blocking : randomized scoreboard bench for dcache_blocking
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_dcache_blocking;

    localparam int LINES = 16;
    localparam int IDX   = 4;

    logic          clk;
    logic          reset;
    logic          cpu_req_valid;
    logic          cpu_req_ready;
    logic [29:0]   cpu_req_addr;
    logic [31:0]   cpu_req_data;
    logic [3:0]    cpu_req_write;
    logic          cpu_resp_valid;
    logic [31:0]   cpu_resp_data;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [27:0]   mem_req_addr;
    logic          mem_req_rw;
    logic          mem_req_data_valid;
    logic          mem_req_data_ready;
    logic [127:0]  mem_req_data_bits;
    logic [15:0]   mem_req_data_mask;
    logic          mem_resp_valid;
    logic [127:0]  mem_resp_data;

    dcache_blocking #(.LINES(LINES)) dut (
        .clk                (clk),
        .reset              (reset),
        .cpu_req_valid      (cpu_req_valid),
        .cpu_req_ready      (cpu_req_ready),
        .cpu_req_addr       (cpu_req_addr),
        .cpu_req_data       (cpu_req_data),
        .cpu_req_write      (cpu_req_write),
        .cpu_resp_valid     (cpu_resp_valid),
        .cpu_resp_data      (cpu_resp_data),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_addr       (mem_req_addr),
        .mem_req_rw         (mem_req_rw),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_req_data_mask  (mem_req_data_mask),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        nvec++;
        nerr++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Behavioural model: a flat word memory plus which line each index holds.
    logic [31:0]  ref_words [int];
    logic [127:0] mem_lines [int];
    bit           res_valid [LINES];
    bit           res_dirty [LINES];
    int           res_tag   [LINES];

    function automatic logic [31:0] init_word(input int wa);
        return (wa * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
    endfunction

    function automatic logic [31:0] ref_rd(input int wa);
        if (ref_words.exists(wa)) return ref_words[wa];
        return init_word(wa);
    endfunction

    function automatic logic [127:0] ref_line(input int la);
        return {ref_rd(la*4+3), ref_rd(la*4+2), ref_rd(la*4+1), ref_rd(la*4)};
    endfunction

    function automatic logic [127:0] mem_rd(input int la);
        if (mem_lines.exists(la)) return mem_lines[la];
        return {init_word(la*4+3), init_word(la*4+2), init_word(la*4+1), init_word(la*4)};
    endfunction

    task automatic preload(input int la, input logic [127:0] line);
        mem_lines[la] = line;
        for (int w = 0; w < 4; w++) ref_words[la*4+w] = line[32*w +: 32];
    endtask

    typedef struct {
        logic [31:0] data;
        int          acc;
        int          lat;
    } resp_t;

    resp_t resp_q[$];
    int    fill_q[$];
    int    wb_q[$];
    int    exp_fills = 0, act_fills = 0, exp_wbs = 0, act_wbs = 0;
    int    hold_fill = 0, hold_data = 0;
    bit    force_lat = 0;

    task automatic issue(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
        int          idx, tag, la, wa, k;
        bit          hit;
        resp_t       r;
        logic [31:0] old;
        k = 0;
        @(negedge clk);
        while (!cpu_req_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (!cpu_req_ready) fail_now("req_ready_timeout");
        idx = int'(a[IDX+1:2]);
        tag = int'(a[29:IDX+2]);
        la  = int'(a[29:2]);
        wa  = int'(a);
        hit = res_valid[idx] && (res_tag[idx] == tag);
        if (!hit) begin
            if (res_valid[idx] && res_dirty[idx]) begin
                wb_q.push_back(res_tag[idx] * LINES + idx);
                exp_wbs++;
            end
            fill_q.push_back(la);
            exp_fills++;
            res_valid[idx] = 1'b1;
            res_tag[idx]   = tag;
            res_dirty[idx] = 1'b0;
        end
        if (be == 4'b0000) begin
            r.data = ref_rd(wa);
            r.acc  = cyc;
            r.lat  = hit ? 2 : 0;
            resp_q.push_back(r);
        end else begin
            old = ref_rd(wa);
            for (int b = 0; b < 4; b++) if (be[b]) old[8*b +: 8] = d[8*b +: 8];
            ref_words[wa]  = old;
            res_dirty[idx] = 1'b1;
        end
        cpu_req_valid = 1'b1;
        cpu_req_addr  = a;
        cpu_req_data  = d;
        cpu_req_write = be;
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
        cpu_req_data  = $urandom;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        @(negedge clk);
        while (!cpu_req_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("done_timeout", 128'(cpu_req_ready), 128'(1));
        chk("fill_count", 128'(act_fills), 128'(exp_fills));
        chk("wb_count", 128'(act_wbs), 128'(exp_wbs));
    endtask

    task automatic do_req(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
        issue(a, d, be);
        wait_done();
    endtask

    // Memory responder: random readiness, optional forced stalls, checks write-backs.
    initial begin : mem_model
        bit         fill_pend, prev_pend, prev_rw, rdy, drdy;
        int         fill_cnt, fill_line, wb_line, e;
        logic [27:0] prev_addr;
        fill_pend = 0; prev_pend = 0; prev_rw = 0; prev_addr = '0;
        fill_cnt = 0; fill_line = 0; wb_line = 0;
        mem_req_ready = 0; mem_req_data_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (!reset) begin
                fill_pend = 0; prev_pend = 0;
                mem_req_ready = 0; mem_req_data_ready = 0;
                continue;
            end
            if (fill_pend) begin
                fill_cnt--;
                if (fill_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_rd(fill_line);
                    fill_pend      = 0;
                end
            end
            if (prev_pend) begin
                chk("req_valid_hold", 128'(mem_req_valid), 128'(1));
                chk("req_addr_hold", 128'({mem_req_rw, mem_req_addr}), 128'({prev_rw, prev_addr}));
            end
            if (mem_req_valid && !mem_req_rw && hold_fill > 0) begin
                rdy = 0;
                hold_fill--;
                chk("stall_cpu_ready_fill", 128'(cpu_req_ready), 128'(0));
            end else begin
                rdy = ($urandom_range(0, 3) != 0);
            end
            mem_req_ready = rdy;
            if (mem_req_valid && rdy) begin
                if (mem_req_rw) begin
                    act_wbs++;
                    wb_line = int'(mem_req_addr);
                    if (wb_q.size() == 0) fail_now("wb_unexpected");
                    else begin
                        e = wb_q.pop_front();
                        chk("wb_addr", 128'(mem_req_addr), 128'(e));
                    end
                end else begin
                    act_fills++;
                    if (fill_q.size() == 0) fail_now("fill_unexpected");
                    else begin
                        e = fill_q.pop_front();
                        chk("fill_addr", 128'(mem_req_addr), 128'(e));
                    end
                    fill_pend = 1;
                    fill_line = int'(mem_req_addr);
                    fill_cnt  = force_lat ? 1000000 : int'($urandom_range(1, 4));
                end
            end
            prev_pend = mem_req_valid && !rdy;
            prev_rw   = mem_req_rw;
            prev_addr = mem_req_addr;
            if (mem_req_data_valid && hold_data > 0) begin
                drdy = 0;
                hold_data--;
                chk("stall_cpu_ready_wb", 128'(cpu_req_ready), 128'(0));
            end else begin
                drdy = ($urandom_range(0, 3) != 0);
            end
            mem_req_data_ready = drdy;
            if (mem_req_data_valid && drdy) begin
                chk("wb_mask", 128'(mem_req_data_mask), 128'(16'hFFFF));
                chk("wb_data", mem_req_data_bits, ref_line(wb_line));
                mem_lines[wb_line] = mem_req_data_bits;
            end
        end
    end

    initial begin : monitor
        resp_t r;
        forever begin
            @(negedge clk);
            if (reset && cpu_resp_valid) begin
                if (resp_q.size() == 0) fail_now("resp_unexpected");
                else begin
                    r = resp_q.pop_front();
                    chk("load_data", 128'(cpu_resp_data), 128'(r.data));
                    if (r.lat != 0) chk("hit_latency", 128'(cyc - r.acc), 128'(r.lat));
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cpu_req_ready"}, 128'(cpu_req_ready), 128'(1));
        chk({tag, "_cpu_resp_valid"}, 128'(cpu_resp_valid), 128'(0));
        chk({tag, "_cpu_resp_data"}, 128'(cpu_resp_data), 128'(0));
        chk({tag, "_mem_req_valid"}, 128'(mem_req_valid), 128'(0));
        chk({tag, "_mem_req_data_valid"}, 128'(mem_req_data_valid), 128'(0));
    endtask

    initial begin : stimulus
        logic [29:0] a;
        int          k;
        reset = 1'b0;
        cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_req_data = '0; cpu_req_write = '0;
        for (int i = 0; i < LINES; i++) begin
            res_valid[i] = 0; res_dirty[i] = 0; res_tag[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b1;

        preload(4, 128'h4444_4444_3333_3333_2222_2222_1111_1111);
        do_req(30'h010, 32'h0, 4'b0000);
        do_req(30'h010, 32'h0, 4'b0000);

        preload(9, {init_word(39), init_word(38), init_word(37), 32'h1234_5678});
        do_req(30'h024, 32'h0, 4'b0000);
        do_req(30'h024, 32'hDEAD_BEEF, 4'b0011);
        do_req(30'h024, 32'h0, 4'b0000);
        chk("merged_word_model", 128'(ref_rd(32'h24)), 128'(32'h1234_BEEF));

        do_req(30'h024 + 30'(LINES*4), 32'h0, 4'b0000);

        do_req(30'h011, 32'hA5A5_5A5A, 4'b1111);
        hold_fill = 5;
        hold_data = 3;
        do_req(30'h011 + 30'(LINES*4), 32'h0, 4'b0000);
        chk("holds_consumed", 128'(hold_fill + hold_data), 128'(0));

        do_req(30'h1A2, 32'h00C3_0000, 4'b0100);
        do_req(30'h1A2 + 30'(LINES*4), 32'h0, 4'b0000);

        for (int n = 0; n < 400; n++) begin
            a = 30'($urandom_range(0, 3) * LINES * 4 + $urandom_range(0, LINES-1) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) do_req(a, 32'h0, 4'b0000);
            else do_req(a, $urandom, 4'($urandom_range(1, 15)));
            if ($urandom_range(0, 49) == 0) begin
                hold_fill = int'($urandom_range(1, 4));
                hold_data = int'($urandom_range(1, 4));
            end
        end

        a = 30'(7 * LINES * 4 + 5 * 4 + 1);
        force_lat = 1;
        issue(a, 32'h0, 4'b0000);
        k = 0;
        while (act_fills != exp_fills && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("reset_fill_accepted", 128'(act_fills), 128'(exp_fills));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        resp_q.delete(); fill_q.delete(); wb_q.delete();
        for (int i = 0; i < LINES; i++) begin
            res_valid[i] = 0; res_dirty[i] = 0;
        end
        ref_words.delete();
        foreach (mem_lines[la]) preload(la, mem_lines[la]);
        force_lat = 0;
        hold_fill = 0;
        hold_data = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        k = exp_fills;
        do_req(a, 32'h0, 4'b0000);
        chk("refill_after_reset", 128'(act_fills - k), 128'(1));

        repeat (10) @(negedge clk);
        chk("resp_queue_empty", 128'(resp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dcache_blocking.md
# dcache_blocking

Blocking, direct-mapped, write-back, write-allocate data cache between the Riscv151 core's data-memory port and the 128-bit main-memory interface. It accepts one word load or store at a time and serves hits from internal register-based storage. On a miss it evicts the dirty victim line if there is one, then refills the whole line before completing the access. The core stalls on `!cpu_req_ready`.

## Interface
- `LINES`, 16: number of lines; power of two, ≥2. `IDX = log2(LINES)`.
- `TAG_W`, 28 − IDX: tag width (24 at default).
- `clk`  in  1  sole clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-low reset; the block is in reset while `reset == 0`.
- `cpu_req_valid`  in  1  core presents a request.
- `cpu_req_ready`  out  1  cache can accept a request.
- `cpu_req_addr`  in  30  word address. Offset = [1:0], index = [IDX+1:2], tag = [29:IDX+2].
- `cpu_req_data`  in  32  store data.
- `cpu_req_write`  in  4  byte enables. 4'b0000 means a load.
- `cpu_resp_valid`  out  1  load data valid, one-cycle pulse.
- `cpu_resp_data`  out  32  load data.
- `mem_req_valid`  out  1  memory command valid.
- `mem_req_ready`  in  1  memory accepts the command.
- `mem_req_addr`  out  28  line address, {tag, index}.
- `mem_req_rw`  out  1  1 = write-back, 0 = refill.
- `mem_req_data_valid`  out  1  write-back data valid.
- `mem_req_data_ready`  in  1  memory accepts the data.
- `mem_req_data_bits`  out  128  victim line; word 0 is in [31:0].
- `mem_req_data_mask`  out  16  byte mask; always 16'hFFFF.
- `mem_resp_valid`  in  1  refill data valid, single beat.
- `mem_resp_data`  in  128  refill line; word 0 is in [31:0].

## Operation
- Per line storage: valid bit, dirty bit, tag, 4×32-bit data words. Valid and dirty are reset; tag and data are not.
- Request capture: a handshake (`cpu_req_valid & cpu_req_ready`) latches addr, data and write into request registers.
- FSM states: IDLE, COMPARE, WB_REQ, WB_DATA, FILL_REQ, FILL_WAIT.
- IDLE: `cpu_req_ready = 1`. A handshake moves the FSM to COMPARE. Otherwise it stays in IDLE.
- COMPARE: hit = valid[idx] & (tag[idx] == req_tag).
  - Load hit: register the selected word into `cpu_resp_data` and pulse `cpu_resp_valid` next cycle. Go to IDLE.
  - Store hit: byte-merge `cpu_req_data` into the word using `cpu_req_write` and set dirty. Go to IDLE. No response.
  - Miss with a valid and dirty victim: go to WB_REQ.
  - Otherwise: go to FILL_REQ.
- WB_REQ: `mem_req_valid = 1`, `rw = 1`, addr = {victim tag, idx}. On `mem_req_ready`, go to WB_DATA.
- WB_DATA: `mem_req_data_valid = 1` with the victim line. On `mem_req_data_ready`, clear dirty and go to FILL_REQ.
- FILL_REQ: `mem_req_valid = 1`, `rw = 0`, addr = {req tag, idx}. On `mem_req_ready`, go to FILL_WAIT.
- FILL_WAIT: on `mem_resp_valid`, write the line, set valid, set tag, clear dirty, and go to COMPARE. The access then completes as a hit.
- `mem_req_valid` is combinational from state and stays stable until accepted. `mem_req_addr` and `mem_req_rw` hold while valid is high.
- Ignored inputs:
  - `mem_resp_valid` outside FILL_WAIT.
  - `mem_req_ready` and `mem_req_data_ready` in states that do not use them.
  - `cpu_req_*` when `cpu_req_ready = 0`.

## Timing
- Reset values, asynchronous, while `reset == 0`:
  - FSM = IDLE.
  - All valid and dirty bits = 0.
  - `cpu_resp_valid = 0`, `cpu_resp_data = 0`.
  - All `mem_*` valid outputs = 0.
  - `cpu_req_ready = 1` (combinational from IDLE).
- Hit latency: accept at edge E0, COMPARE during the cycle after E0, `cpu_resp_valid` high during the cycle after E1. That is 2 cycles from acceptance to response, 1 request per 2 cycles.
- `cpu_req_ready` is high in the same cycle as the load response, so back-to-back requests are allowed.
- Clean miss: 2 (COMPARE, FILL_REQ minimum) + memory latency + 1 COMPARE + 1 response cycle.
- Dirty miss adds WB_REQ and WB_DATA, each at least 1 cycle.
- Hold states: WB_REQ, WB_DATA and FILL_REQ hold indefinitely while their ready input is low. FILL_WAIT waits indefinitely for `mem_resp_valid`.
- Write-back data must reflect line contents, including stores completed earlier in the same cycle-sequence.
- Mid-operation reset: abort any transaction, drop all mem valids asynchronously, invalidate all lines. The pending request is lost.
- Different address, same index: evicts. Same line re-access after a refill: hits.

## Test plan
- Load 0x000_0010 after reset → miss, `mem_req_addr = 0x000_0004`, `rw = 0`. Return 128'h…4444_3333_2222_1111 → `cpu_resp_data = 0x1111_1111`. A repeat load hits with a 2-cycle response.
- Store 0xDEADBEEF with write 4'b0011 to a resident word holding 0x1234_5678 → a later load returns 0x1234_BEEF, and no mem traffic occurs.
- Dirty eviction: store to addr A, then load A + (LINES×4) (same index) → WB_REQ with addr {tagA, idx}, `rw = 1`, data containing the stored word, mask 16'hFFFF. Then a refill of the new tag.
- Backpressure: hold `mem_req_ready = 0` for 5 cycles in FILL_REQ and `mem_req_data_ready = 0` for 3 cycles in WB_DATA → outputs stay stable, `cpu_req_ready` stays 0, completion is correct.
- Store miss to a clean line → refill, then merge. A subsequent eviction writes back the merged word.
- Reset pulled low during FILL_WAIT → all outputs return to reset values immediately. After release, the previously filled address misses again.
